// File: rtl/sample_stream_tx.sv
// Transmit side of the wavelet front-end sample interface: a small sample FIFO
// drained onto a parallel value bus qualified by a slow, registered data strobe.
module sample_stream_tx #(
    parameter int BITS_PER_ELEM = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 2,
    parameter int HIGH_CYCLES   = 2,
    parameter int LOW_CYCLES    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic signed [BITS_PER_ELEM-1:0] i_sample,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic                            i_flush,
    output logic signed [BITS_PER_ELEM-1:0] o_value,
    output logic                            o_data_clk,
    output logic                            o_busy,
    output logic [$clog2(FIFO_DEPTH):0]     o_level,
    output logic [15:0]                     o_sent
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int MAXC  = (SETUP_CYCLES > HIGH_CYCLES)
                         ? ((SETUP_CYCLES > LOW_CYCLES) ? SETUP_CYCLES : LOW_CYCLES)
                         : ((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES);
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] SETUP_L = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_L  = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_L   = CNT_W'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW
    } state_t;

    logic signed [BITS_PER_ELEM-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                r_wr_ptr;
    logic [PTR_W-1:0]                r_rd_ptr;
    logic [LVL_W-1:0]                r_level;
    state_t                          r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic signed [BITS_PER_ELEM-1:0] r_value;
    logic                            r_data_clk;
    logic [15:0]                     r_sent;

    logic w_fifo_ne;
    logic w_pop_slot;
    logic w_push;
    logic w_pop;

    assign w_fifo_ne  = (r_level != '0);
    assign w_pop_slot = (r_state == S_IDLE) || ((r_state == S_LOW) && (r_cnt == '0));
    // Flush wins over both a same-edge push and a same-edge pop.
    assign w_push     = i_valid & o_ready & ~i_flush;
    assign w_pop      = w_pop_slot & w_fifo_ne & ~i_flush;

    assign o_ready    = rst_n & (r_level < DEPTH_L);
    assign o_busy     = (r_state != S_IDLE) || w_fifo_ne;
    assign o_level    = r_level;
    assign o_value    = r_value;
    assign o_data_clk = r_data_clk;
    assign o_sent     = r_sent;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Strobe sequencer: o_value changes only on a pop, so it is held across the whole pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_value    <= '0;
            r_data_clk <= 1'b0;
            r_sent     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_data_clk <= 1'b0;
                    if (w_pop) begin
                        r_value <= r_mem[r_rd_ptr];
                        r_cnt   <= SETUP_L;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_data_clk <= 1'b1;
                        r_cnt      <= HIGH_L;
                        r_state    <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        r_data_clk <= 1'b0;
                        r_sent     <= r_sent + 16'd1;
                        r_cnt      <= LOW_L;
                        r_state    <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_LOW: begin
                    if (r_cnt == '0) begin
                        if (w_pop) begin
                            r_value <= r_mem[r_rd_ptr];
                            r_cnt   <= SETUP_L;
                            r_state <= S_SETUP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_data_clk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_stream_tx.sv
// Scoreboard bench for sample_stream_tx: accepted pushes feed an expected queue,
// a receiver-style monitor checks every strobe rise and fall against it.
module tb_sample_stream_tx;

    localparam int W = 8;
    localparam int D = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] i_sample = '0;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic                i_flush = 1'b0;
    logic signed [W-1:0] o_value;
    logic                o_data_clk;
    logic                o_busy;
    logic [2:0]          o_level;
    logic [15:0]         o_sent;

    sample_stream_tx dut (
        .clk(clk), .rst_n(rst_n), .i_sample(i_sample), .i_valid(i_valid),
        .o_ready(o_ready), .i_flush(i_flush), .o_value(o_value),
        .o_data_clk(o_data_clk), .o_busy(o_busy), .o_level(o_level), .o_sent(o_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] exp_q[$];
    logic signed [W-1:0] rx_q[$];
    int   rise_cyc[$];
    int   model_sent = 0;
    logic prev_dclk = 1'b0;
    int   ready_bad = 0;
    bit   saw_full = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Receiver model: a reset discards everything queued or in flight.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_sent = 0;
            prev_dclk  = o_data_clk;
        end else begin
            if ((o_level < D) != o_ready) ready_bad++;
            if (o_level == D && !o_ready) saw_full = 1'b1;
            if (o_data_clk && !prev_dclk) begin
                rise_cyc.push_back(cyc);
                rx_q.push_back(o_value);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: got value %0d expected no strobe", o_value);
                end else begin
                    chk("strobe_value", o_value, exp_q.pop_front());
                end
            end
            if (!o_data_clk && prev_dclk) begin
                model_sent = (model_sent + 1) % 65536;
                chk("sent_on_fall", {16'd0, o_sent}, model_sent);
            end
            prev_dclk = o_data_clk;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves i_valid high on return so callers can stream back-to-back.
    task automatic push_one(input logic signed [W-1:0] v);
        bit acc;
        i_sample = v;
        i_valid  = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = o_ready && !i_flush;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(v);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL push_timeout: got no ready expected ready within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 1000; n++) begin
            if (!o_busy) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy expected idle within 1000 cycles");
    endtask

    task automatic wait_dclk_high();
        for (int n = 0; n < 100; n++) begin
            if (o_data_clk) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL strobe_timeout: got no strobe expected strobe within 100 cycles");
    endtask

    logic signed [W-1:0] burst [6] = '{-8'sd128, -8'sd1, 8'sd0, 8'sd1, 8'sd127, 8'sh33};
    int base;

    initial begin
        // Reset with valid held high: nothing may be accepted.
        rst_n = 1'b0;
        i_valid = 1'b1;
        i_sample = 8'sh11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_ready", {31'd0, o_ready}, 0);
        end
        chk("reset_value", o_value, 0);
        chk("reset_dclk", {31'd0, o_data_clk}, 0);
        chk("reset_level", {29'd0, o_level}, 0);
        chk("reset_sent", {16'd0, o_sent}, 0);
        i_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_reset_level", {29'd0, o_level}, 0);
        chk("post_reset_busy", {31'd0, o_busy}, 0);

        // Single sample edge-by-edge timing.
        push_one(8'sh5A);
        i_valid = 1'b0;
        step(); chk("single_value_e1", o_value, 32'h5A);
                chk("single_dclk_e1", {31'd0, o_data_clk}, 0);
        step(); chk("single_dclk_e2", {31'd0, o_data_clk}, 0);
        step(); chk("single_dclk_e3", {31'd0, o_data_clk}, 1);
        step(); chk("single_dclk_e4", {31'd0, o_data_clk}, 1);
        step(); chk("single_dclk_e5", {31'd0, o_data_clk}, 0);
                chk("single_sent_e5", {16'd0, o_sent}, 1);
        step(); chk("single_busy_e6", {31'd0, o_busy}, 1);
        step(); chk("single_busy_e7", {31'd0, o_busy}, 0);

        // Burst of boundary values with valid held: FIFO fills, strobes every 6 cycles.
        base = rise_cyc.size();
        saw_full = 1'b0;
        foreach (burst[i]) push_one(burst[i]);
        i_valid = 1'b0;
        wait_idle();
        chk("burst_rises", rise_cyc.size() - base, 6);
        for (int i = base + 1; i < base + 6 && i < rise_cyc.size(); i++)
            chk("burst_period", rise_cyc[i] - rise_cyc[i-1], 6);
        chk("burst_sent", {16'd0, o_sent}, 7);
        chk("burst_hold_value", o_value, 32'h33);
        chk("burst_saw_full", {31'd0, saw_full}, 1);

        // Flush during the first sample's high phase.
        base = rise_cyc.size();
        for (int v = 16; v < 20; v++) push_one(W'(v));
        i_valid = 1'b0;
        wait_dclk_high();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        // The head already strobed; everything still queued is gone.
        exp_q.delete();
        chk("flush_level", {29'd0, o_level}, 0);
        wait_idle();
        repeat (10) step();
        chk("flush_rises", rise_cyc.size() - base, 1);
        chk("flush_sent", {16'd0, o_sent}, 8);
        chk("flush_value", o_value, 32'h10);

        // Reset while the strobe is high.
        push_one(8'sh21);
        push_one(8'sh22);
        i_valid = 1'b0;
        wait_dclk_high();
        rst_n = 1'b0;
        step();
        chk("rst_high_dclk", {31'd0, o_data_clk}, 0);
        chk("rst_high_level", {29'd0, o_level}, 0);
        chk("rst_high_sent", {16'd0, o_sent}, 0);
        chk("rst_high_ready", {31'd0, o_ready}, 0);
        step();
        rst_n = 1'b1;
        base = rise_cyc.size();
        repeat (12) step();
        chk("rst_high_no_strobe", rise_cyc.size() - base, 0);
        chk("rst_high_busy", {31'd0, o_busy}, 0);

        // Ramp playback with random gaps; receiver must hold the ramp in order.
        base = rx_q.size();
        for (int v = 0; v < 16; v++) begin
            repeat ($urandom_range(0, 8)) step();
            push_one(W'(v));
            i_valid = 1'b0;
        end
        wait_idle();
        chk("ramp_sent", {16'd0, o_sent}, 16);
        chk("ramp_count", rx_q.size() - base, 16);
        for (int v = 0; v < 16 && base + v < rx_q.size(); v++)
            chk("ramp_rx", rx_q[base + v], v);

        // Random values with random gaps or back-to-back streaming.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                i_valid = 1'b0;
                repeat ($urandom_range(1, 10)) step();
            end
            push_one(W'($urandom));
        end
        i_valid = 1'b0;
        wait_idle();
        chk("random_drained", exp_q.size(), 0);
        chk("random_sent", {16'd0, o_sent}, 46);
        chk("ready_tracks_level", ready_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
